fir_serial_mac_param: RTL and testbench

//  Next-generation time-multiplexed FIR: one MAC, one output per TAPS enabled cycles.
//  Tap count and all widths are parameters; coefficients are double-buffered (active/shadow)

---
 rtl/fir_serial_mac_param.sv | 185 ++++++++++++++++++
 tb/tb_fir_serial_mac_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac_param.sv
// fir_serial_mac_param
//   Time-multiplexed FIR filter: a single multiply-accumulate unit walks all
//   TAPS taps of a frame, one tap per enabled clock, producing one output per
//   TAPS enabled cycles. Coefficients are double-buffered (active/shadow bank)
//   and the bank swap is aligned to a frame boundary so every frame is computed
//   with exactly one coefficient set.
//
//   Optional build macro FIR_ROUND_SAT_EN: output scaling rounds half up and
//   saturates to OUT_W. Without it the output is a floor shift with
//   two's-complement wrap to OUT_W bits.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clk_enable      global enable; low freezes all state and ignores inputs
//   filter_in       sample, captured when in_ready is high
//   in_ready        clk_enable & (count == TAPS-1), combinational
//   write_enable    write coeffs_in to shadow bank at write_address
//   write_address   tap index
//   coeffs_in       coefficient, Q(COEF_FRAC)
//   write_done      request shadow->active swap at the next frame boundary
//   coeffs_busy     swap pending; shadow writes are dropped meanwhile
//   filter_out      registered result
//   out_valid       one-clock pulse when filter_out updates

module fir_serial_mac_param #(
    parameter int TAPS      = 64,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 18,
    parameter int OUT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_enable,
    input  logic signed [DATA_W-1:0]    filter_in,
    output logic                        in_ready,
    input  logic                        write_enable,
    input  logic [$clog2(TAPS)-1:0]     write_address,
    input  logic signed [COEF_W-1:0]    coeffs_in,
    input  logic                        write_done,
    output logic                        coeffs_busy,
    output logic signed [OUT_W-1:0]     filter_out,
    output logic                        out_valid
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    logic [ADDR_W-1:0]          count;
    logic signed [DATA_W-1:0]   x_dl   [TAPS];
    logic signed [COEF_W-1:0]   coef_b0[TAPS];
    logic signed [COEF_W-1:0]   coef_b1[TAPS];
    logic                       bank_sel;
    logic signed [ACC_W-1:0]    acc;
    logic                       frame_valid;   // a full frame has run since reset

    logic                       last;
    logic                       coef_we;
    logic signed [DATA_W-1:0]   x_cur;
    logic signed [COEF_W-1:0]   c_cur;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [OUT_W-1:0]    scaled;

    assign last     = (count == LAST);
    assign in_ready = clk_enable & last;
    assign coef_we  = clk_enable & write_enable & ~coeffs_busy;

    assign x_cur    = x_dl[count];
    assign c_cur    = bank_sel ? coef_b1[count] : coef_b0[count];
    assign prod     = x_cur * c_cur;
    assign prod_ext = {{ADDR_W{prod[PROD_W-1]}}, prod};

    // ---------------- output scaling ----------------
`ifdef FIR_ROUND_SAT_EN
    // One guard bit so adding the rounding constant can never overflow.
    localparam logic signed [ACC_W:0] HALF =
        {{(ACC_W - COEF_FRAC + 1){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W:0] acc_rnd;
    logic signed [ACC_W:0] acc_sh;

    assign acc_rnd = $signed({acc[ACC_W-1], acc}) + HALF;
    assign acc_sh  = acc_rnd >>> COEF_FRAC;

    always_comb begin
        scaled = acc_sh[OUT_W-1:0];
        if (acc_sh > SAT_MAX)
            scaled = {1'b0, {(OUT_W - 1){1'b1}}};
        else if (acc_sh < SAT_MIN)
            scaled = {1'b1, {(OUT_W - 1){1'b0}}};
    end
`else
    assign scaled = OUT_W'(acc >>> COEF_FRAC);
`endif

    // ---------------- tap counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clk_enable)
            count <= count + 1'b1;   // TAPS is a power of 2: natural wrap
    end

    // ---------------- delay line ----------------
    // Shifts only at the frame boundary so it is stable for a whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) x_dl[k] <= '0;
        end else if (in_ready) begin
            x_dl[0] <= filter_in;
            for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
        end
    end

    // ---------------- coefficient banks ----------------
    // Writes always target the inactive bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_b0[k] <= '0;
                coef_b1[k] <= '0;
            end
        end else if (coef_we) begin
            if (bank_sel)
                coef_b0[write_address] <= coeffs_in;
            else
                coef_b1[write_address] <= coeffs_in;
        end
    end

    // Swap only at the last tap of a frame so the next frame starts on the new
    // bank. A request raised on that same edge waits a full frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel    <= 1'b0;
            coeffs_busy <= 1'b0;
        end else if (clk_enable) begin
            if (coeffs_busy && last) begin
                bank_sel    <= ~bank_sel;
                coeffs_busy <= 1'b0;
            end else if (write_done && !coeffs_busy) begin
                coeffs_busy <= 1'b1;
            end
        end
    end

    // ---------------- MAC ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clk_enable)
            acc <= (count == '0) ? prod_ext : acc + prod_ext;
    end

    // ---------------- output ----------------
    // The first count==0 edge after reset has no completed frame behind it,
    // so it is suppressed; an aborted frame never produces out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_valid <= 1'b0;
        else if (clk_enable && last)
            frame_valid <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clk_enable && count == '0 && frame_valid) begin
                filter_out <= scaled;
                out_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_serial_mac_param.sv
module tb_fir_serial_mac_param;

    localparam int TAPS      = 64;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 18;
    localparam int OUT_W     = 16;
    localparam int AW        = $clog2(TAPS);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      clk_enable;
    logic signed [DATA_W-1:0]  filter_in;
    logic                      in_ready;
    logic                      write_enable;
    logic [AW-1:0]             write_address;
    logic signed [COEF_W-1:0]  coeffs_in;
    logic                      write_done;
    logic                      coeffs_busy;
    logic signed [OUT_W-1:0]   filter_out;
    logic                      out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_serial_mac_param #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .COEF_FRAC(COEF_FRAC), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .filter_in(filter_in), .in_ready(in_ready),
        .write_enable(write_enable), .write_address(write_address),
        .coeffs_in(coeffs_in), .write_done(write_done),
        .coeffs_busy(coeffs_busy), .filter_out(filter_out),
        .out_valid(out_valid)
    );

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: a frame is TAPS enabled cycles; at its end the result
    // is the dot product of the sample history and the coefficient set that
    // was active for that frame.
    int      ph;
    bit      pend;
    longint  hist[TAPS];
    longint  act [TAPS];
    longint  shd [TAPS];
    longint  tmp [TAPS];
    longint  dot;
    int      exp_q[$];
    int      outs[$];

    function automatic int scale(input longint a);
        longint s;
        logic signed [OUT_W-1:0] t;
`ifdef FIR_ROUND_SAT_EN
        s = (a + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
        if (s > (longint'(1) << (OUT_W - 1)) - 1) s = (longint'(1) << (OUT_W - 1)) - 1;
        if (s < -(longint'(1) << (OUT_W - 1)))    s = -(longint'(1) << (OUT_W - 1));
        t = s[OUT_W-1:0];
`else
        s = a >>> COEF_FRAC;
        t = s[OUT_W-1:0];
`endif
        return int'(t);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
            pend = 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                hist[k] = 0; act[k] = 0; shd[k] = 0;
            end
            exp_q.delete();
        end else if (clk_enable) begin
            if (write_enable && !pend) shd[write_address] = coeffs_in;
            if (ph == TAPS - 1) begin
                dot = 0;
                for (int k = 0; k < TAPS; k++) dot += hist[k] * act[k];
                exp_q.push_back(scale(dot));
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = filter_in;
                if (pend) begin
                    tmp = act; act = shd; shd = tmp;
                    pend = 1'b0;
                end else if (write_done) begin
                    pend = 1'b1;
                end
            end else if (write_done && !pend) begin
                pend = 1'b1;
            end
            ph = (ph + 1) % TAPS;
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("reset_filter_out", filter_out, 0);
            check("reset_out_valid", out_valid, 0);
            check("reset_busy", coeffs_busy, 0);
            check("reset_in_ready", in_ready, 0);
        end else begin
            check("busy", coeffs_busy, pend);
            check("in_ready", in_ready, (clk_enable && ph == TAPS - 1));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("filter_out", filter_out, exp_q.pop_front());
                    outs.push_back(int'(filter_out));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit en, input bit we, input int addr, input int cv,
                       input bit wd, input int xin);
        @(negedge clk);
        clk_enable    = en;
        write_enable  = we;
        write_address = AW'(addr);
        coeffs_in     = COEF_W'(cv);
        write_done    = wd;
        filter_in     = DATA_W'(xin);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        clk_enable = 1'b0; write_enable = 1'b0; write_done = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int xin);
        for (int i = 0; i < TAPS; i++) cyc(1, 0, 0, 0, 0, xin);
    endtask

    // One frame: two writes, then write_done; swap lands at the frame's end.
    task automatic load_and_swap(input int a0, input int c0, input int a1, input int c1);
        cyc(1, 1, a0, c0, 0, 0);
        cyc(1, 1, a1, c1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 3; i < TAPS; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic check_outs_at(input string name, input int idx, input int want);
        if (outs.size() <= idx) check({name, "_missing"}, outs.size(), idx + 1);
        else                    check(name, outs[idx], want);
    endtask

    initial begin
        rst = 1'b1; clk_enable = 1'b0; filter_in = '0; write_enable = 1'b0;
        write_address = '0; coeffs_in = '0; write_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: no coefficients loaded, impulse -> all zeros
        outs.delete();
        run_frame(16000);
        repeat (3) run_frame(0);
        check("t1_count", outs.size(), 3);
        foreach (outs[i]) check("t1_zero", outs[i], 0);

        // 2: c[0]=16384, c[3]=-8192, impulse 16000
        do_reset(2);
        load_and_swap(0, 16384, 3, -8192);
        outs.delete();
        run_frame(16000);
        repeat (5) run_frame(0);
        check_outs_at("t2_o0", 0, 0);
        check_outs_at("t2_o1", 1, 0);
        check_outs_at("t2_o2", 2, 1000);
        check_outs_at("t2_o3", 3, 0);
        check_outs_at("t2_o4", 4, 0);
        check_outs_at("t2_o5", 5, -500);

        // 3: mid-frame write_done, dropped write while busy
        do_reset(2);
        for (int i = 0; i < TAPS; i++) begin
            if (i == 10)      cyc(1, 1, 0, 4096, 1, 0);
            else if (i == 20) cyc(1, 1, 0, 8192, 0, 0);
            else              cyc(1, 0, 0, 0, 0, 0);
            if (i == 30) check("t3_busy_mid", coeffs_busy, 1);
        end
        outs.delete();
        cyc(1, 0, 0, 0, 0, 1024);
        check("t3_busy_after_swap", coeffs_busy, 0);
        for (int i = 1; i < TAPS; i++) cyc(1, 0, 0, 0, 0, 1024);
        repeat (2) run_frame(0);
        check_outs_at("t3_readback", 2, 16);

        // 4: full-scale sums
        do_reset(2);
        for (int i = 0; i < TAPS; i++) cyc(1, 1, i, 32767, (i == TAPS - 1), 0);
        outs.delete();
        repeat (66) run_frame(32767);
`ifdef FIR_ROUND_SAT_EN
        check_outs_at("t4_pos_full", outs.size() - 1, 32767);
`else
        check_outs_at("t4_pos_full", outs.size() - 1, -16);
`endif
        outs.delete();
        repeat (66) run_frame(-32768);
`ifdef FIR_ROUND_SAT_EN
        check_outs_at("t4_neg_full", outs.size() - 1, -32768);
`else
        check_outs_at("t4_neg_full", outs.size() - 1, 8);
`endif

        // 5: rounding boundaries
        do_reset(2);
        load_and_swap(0, 4, 1, 0);
        outs.delete();
        repeat (3) run_frame(-32768);
`ifdef FIR_ROUND_SAT_EN
        check_outs_at("t5_half_neg", 2, 0);
`else
        check_outs_at("t5_half_neg", 2, -1);
`endif
        load_and_swap(0, 6, 1, 0);
        outs.delete();
        repeat (3) run_frame(32767);
`ifdef FIR_ROUND_SAT_EN
        check_outs_at("t5_three_q", 2, 1);
`else
        check_outs_at("t5_three_q", 2, 0);
`endif

        // 6: random enables, writes, swaps and mid-frame resets
        do_reset(2);
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cyc(($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, TAPS - 1)),
                    int'($urandom_range(0, 65535)),
                    ($urandom_range(0, 39) == 0),
                    int'($urandom_range(0, 65535)));
            end
        end
        for (int i = 0; i < 2 * TAPS + 4; i++) cyc(1, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check("drain_pending_le1", (exp_q.size() <= 1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
